// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory programmer.
// Receives a framed byte stream (SYNC, COUNT, COUNT*4 data bytes LSB first,
// CSUM), writes little-endian words to the instruction memory and releases
// the core reset only after the whole image has been checksum-verified.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned DEPTH          = 256,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [8:0]  words_loaded
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, COUNT, DATA, CSUM, DONE, ERROR} state_t;

  state_t        state_q, state_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [8:0]    word_idx_q, word_idx_d;
  logic [8:0]    count_q, count_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   asm_q, asm_d;

  logic          mem_write_d;
  logic [31:0]   mem_addr_d;
  logic [31:0]   mem_data_d;
  logic          cpu_reset_d;
  logic          busy_d;
  logic          done_d;
  logic          error_d;
  logic [8:0]    words_loaded_d;
  logic [8:0]    n;

  // State and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      byte_idx_q   <= '0;
      word_idx_q   <= '0;
      count_q      <= '0;
      csum_q       <= '0;
      tmo_q        <= '0;
      asm_q        <= '0;
      mem_write    <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_data     <= '0;
      cpu_reset    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_idx_q   <= word_idx_d;
      count_q      <= count_d;
      csum_q       <= csum_d;
      tmo_q        <= tmo_d;
      asm_q        <= asm_d;
      mem_write    <= mem_write_d;
      mem_addr     <= mem_addr_d;
      mem_data     <= mem_data_d;
      cpu_reset    <= cpu_reset_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
      words_loaded <= words_loaded_d;
    end
  end

  // Next-state and next-output logic; the word write is issued from the
  // edge that samples the 4th byte, so it never depends on the next state.
  always_comb begin
    state_d        = state_q;
    byte_idx_d     = byte_idx_q;
    word_idx_d     = word_idx_q;
    count_d        = count_q;
    csum_d         = csum_q;
    tmo_d          = '0;
    asm_d          = asm_q;
    mem_write_d    = 1'b0;
    mem_addr_d     = mem_addr;
    mem_data_d     = mem_data;
    cpu_reset_d    = cpu_reset;
    busy_d         = busy;
    done_d         = done;
    error_d        = error;
    words_loaded_d = words_loaded;
    n              = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};

    case (state_q)
      IDLE, ERROR: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d        = COUNT;
          busy_d         = 1'b1;
          error_d        = 1'b0;
          words_loaded_d = '0;
          word_idx_d     = '0;
          byte_idx_d     = '0;
          csum_d         = '0;
        end
      end

      COUNT, DATA, CSUM: begin
        if (rx_valid) begin
          case (state_q)
            COUNT: begin
              if ({23'b0, n} > DEPTH) begin
                state_d = ERROR;
                error_d = 1'b1;
                busy_d  = 1'b0;
              end else begin
                count_d = n;
                state_d = DATA;
              end
            end
            DATA: begin
              asm_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
              csum_d     = csum_q + rx_data;
              byte_idx_d = byte_idx_q + 2'd1;
              if (byte_idx_q == 2'd3) begin
                mem_write_d    = 1'b1;
                mem_addr_d     = BASE_ADDR + {21'b0, word_idx_q, 2'b00};
                mem_data_d     = {rx_data, asm_q[23:0]};
                words_loaded_d = words_loaded + 9'd1;
                word_idx_d     = word_idx_q + 9'd1;
                if (word_idx_q == count_q - 9'd1)
                  state_d = CSUM;
              end
            end
            default: begin
              if (rx_data == csum_q) begin
                state_d     = DONE;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                cpu_reset_d = 1'b0;
              end else begin
                state_d = ERROR;
                error_d = 1'b1;
                busy_d  = 1'b0;
              end
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          state_d     = ERROR;
          error_d     = 1'b1;
          busy_d      = 1'b0;
          cpu_reset_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: ;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed test of imem_loader with immediate-assertion checks.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  logic        mem_write, cpu_reset, busy, done, error;
  logic [31:0] mem_addr, mem_data;
  logic [8:0]  words_loaded;

  logic        s_mem_write, s_cpu_reset, s_busy, s_done, s_error;
  logic [31:0] s_mem_addr, s_mem_data;
  logic [8:0]  s_words_loaded;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t wq[$];
  logic [7:0] frame[$];

  always #5 clk = ~clk;

  imem_loader #(
    .BASE_ADDR(32'h0000_0000), .DEPTH(256), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  imem_loader #(
    .BASE_ADDR(32'h0000_0000), .DEPTH(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)
  ) dut_small (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_write(s_mem_write), .mem_addr(s_mem_addr), .mem_data(s_mem_data),
    .cpu_reset(s_cpu_reset), .busy(s_busy), .done(s_done), .error(s_error),
    .words_loaded(s_words_loaded)
  );

  // Capture every write pulse of the main instance, 2 ns after the edge.
  always begin
    @(posedge clk);
    #2;
    if (mem_write === 1'b1) wq.push_back('{a: mem_addr, d: mem_data});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    logic [63:0] obs;
    obs = (idx < wq.size()) ? {wq[idx].a, wq[idx].d} : 64'hx;
    check(tag, obs, {a, d});
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input int gap);
    foreach (frame[i]) send_byte(frame[i], gap);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wq.delete();
  endtask

  initial begin
    int bad;
    logic [7:0] ck;

    // Reset state
    @(negedge clk);
    do_reset();
    check("rst cpu_reset", cpu_reset, 1);
    check("rst mem_write", mem_write, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_data", mem_data, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst error", error, 0);
    check("rst words", words_loaded, 0);

    // 1: two-word frame with gaps
    frame = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    send_frame(2);
    check("t1 nwrites", wq.size(), 2);
    check_wr("t1 wr0", 0, 32'h0, 32'h0000_0013);
    check_wr("t1 wr1", 1, 32'h4, 32'h0010_0093);
    check("t1 done", done, 1);
    check("t1 cpu_reset", cpu_reset, 0);
    check("t1 words", words_loaded, 2);
    check("t1 error", error, 0);
    check("t1 busy", busy, 0);

    // 2: bad checksum, then recovery
    do_reset();
    frame = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'hB7};
    send_frame(1);
    check("t2 nwrites", wq.size(), 2);
    check_wr("t2 wr1", 1, 32'h4, 32'h0010_0093);
    check("t2 error", error, 1);
    check("t2 cpu_reset", cpu_reset, 1);
    check("t2 done", done, 0);
    check("t2 busy", busy, 0);
    send_byte(8'hA5, 0);
    check("t2 err clr", error, 0);
    check("t2 busy again", busy, 1);
    frame = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    send_frame(1);
    check("t2 nwrites2", wq.size(), 4);
    check_wr("t2 wr2", 2, 32'h0, 32'h0000_0013);
    check("t2 done", done, 1);
    check("t2 cpu_rel", cpu_reset, 0);

    // 3: garbage before a one-word frame; EF+BE+AD+DE = 0x338 -> CSUM 0x38
    do_reset();
    frame = '{8'h00, 8'hFF, 8'h5A};
    send_frame(1);
    check("t3 garbage nw", wq.size(), 0);
    check("t3 garbage busy", busy, 0);
    frame = '{8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
    send_frame(1);
    check("t3 nwrites", wq.size(), 1);
    check_wr("t3 wr0", 0, 32'h0, 32'hDEAD_BEEF);
    check("t3 done", done, 1);

    // 4: timeout 16 cycles after the last sampled byte
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h13, 0);
    repeat (15) @(negedge clk);
    check("t4 err early", error, 0);
    check("t4 busy early", busy, 1);
    @(negedge clk);
    check("t4 err at 16", error, 1);
    check("t4 busy", busy, 0);
    check("t4 cpu_reset", cpu_reset, 1);
    check("t4 nwrites", wq.size(), 0);

    // 5: 256 words back to back, word i = i; CSUM = sum(0..255) mod 256 = 0x80
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    ck = 8'h00;
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i), 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      ck = ck + 8'(i);
    end
    check("t5 ck model", ck, 8'h80);
    send_byte(ck, 2);
    check("t5 nwrites", wq.size(), 256);
    bad = 0;
    for (int i = 0; i < 256 && i < wq.size(); i++)
      if (wq[i].a !== 32'(4 * i) || wq[i].d !== 32'(i)) bad++;
    check("t5 bad words", bad, 0);
    check_wr("t5 last", 255, 32'h3FC, 32'h0000_00FF);
    check("t5 words", words_loaded, 256);
    check("t5 done", done, 1);
    check("t5 small err", s_error, 1);

    // 5b: DEPTH=16 boundary on the count byte
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h20, 0);
    check("t5b small err", s_error, 1);
    check("t5b small busy", s_busy, 0);
    check("t5b big err", error, 0);
    check("t5b big busy", busy, 1);
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h10, 0);
    check("t5b 16 ok err", s_error, 0);
    check("t5b 16 ok busy", s_busy, 1);

    // 6: reset mid-frame, then a fresh frame loads from BASE_ADDR
    do_reset();
    frame = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_frame(0);
    @(negedge clk);
    check("t6 pre nwrites", wq.size(), 1);
    check_wr("t6 pre wr0", 0, 32'h0, 32'h4433_2211);
    check("t6 pre words", words_loaded, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6 rst mem_addr", mem_addr, 0);
    check("t6 rst mem_data", mem_data, 0);
    check("t6 rst words", words_loaded, 0);
    check("t6 rst busy", busy, 0);
    check("t6 rst cpu", cpu_reset, 1);
    check("t6 rst wr", mem_write, 0);
    check("t6 rst small wl", s_words_loaded, 0);
    check("t6 rst small done", s_done, 0);
    check("t6 rst small cpu", s_cpu_reset, 1);
    check("t6 rst small wr", s_mem_write, 0);
    check("t6 rst small addr", s_mem_addr, 0);
    check("t6 rst small data", s_mem_data, 0);
    wq.delete();
    frame = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    send_frame(1);
    check("t6 nwrites", wq.size(), 1);
    check_wr("t6 wr0", 0, 32'h0, 32'h0403_0201);
    check("t6 done", done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
